store_byte_arbiter: RTL

- Shares a single store_byte cell between NUM_REQ requesters using round-robin arbitration.
- Sequences each granted transaction onto the store: a one-cycle write_enable pulse, or a read_enable pulse followed by a wait for output_enable.
- Returns a per-requester response and flags reads that time out.
- Sits between client logic and the store_byte instance; it is the only driver of the store's enables.

---
 rtl/store_byte_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/store_byte_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/store_byte_pkg.sv
// Shared types and constants for the store_byte arbiter slice.
package store_byte_pkg;

  localparam int DATA_W_DEFAULT = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant,
// searching in ascending order and wrapping, wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;
  int   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_byte_arbiter.sv
// Round-robin front end for a single store_byte cell: grants one requester,
// sequences its write or read onto the store and returns a response pulse.
//
// state | meaning
// IDLE  | offering a grant; handshake on valid & ready
// WRITE | one-cycle write_enable with latched data on the store
// READ  | one-cycle read_enable; timeout counter loaded
// WAIT  | waiting for output_enable, counting down to the timeout
// RESP  | one-cycle rsp_valid to the granted requester
module store_byte_arbiter
  import store_byte_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_error,
  output logic                      busy,
  output logic                      st_write_enable,
  output logic                      st_read_enable,
  output logic [DATA_W-1:0]         st_data_in,
  input  logic [DATA_W-1:0]         st_data_out,
  input  logic                      st_output_enable
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     cur_idx;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]     gnt_idx;
  logic [CNT_W-1:0]     tmo_cnt;
  logic                 handshake;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (gnt_oh),
    .grant_idx  (gnt_idx)
  );

  // Ready is masked by rst so every output reads 0 while reset is held.
  assign req_ready = (state == IDLE && !rst) ? gnt_oh : '0;
  assign handshake = |req_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= IDX_W'(NUM_REQ - 1);
      cur_idx         <= '0;
      tmo_cnt         <= '0;
      rsp_valid       <= '0;
      rsp_data        <= '0;
      rsp_error       <= 1'b0;
      st_write_enable <= 1'b0;
      st_read_enable  <= 1'b0;
      st_data_in      <= '0;
    end else begin
      st_write_enable <= 1'b0;
      st_read_enable  <= 1'b0;
      st_data_in      <= '0;
      rsp_valid       <= '0;
      rsp_data        <= '0;
      rsp_error       <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            cur_idx    <= gnt_idx;
            last_grant <= gnt_idx;
            if (req_write[gnt_idx] == OP_WRITE) begin
              state           <= WRITE;
              st_write_enable <= 1'b1;
              st_data_in      <= req_wdata[gnt_idx*DATA_W +: DATA_W];
            end else begin
              state          <= READ;
              st_read_enable <= 1'b1;
            end
          end
        end
        WRITE: begin
          state              <= RESP;
          rsp_valid[cur_idx] <= 1'b1;
        end
        READ: begin
          state   <= WAIT;
          tmo_cnt <= CNT_W'(RD_TIMEOUT - 1);
        end
        WAIT: begin
          if (st_output_enable) begin
            state              <= RESP;
            rsp_valid[cur_idx] <= 1'b1;
            rsp_data           <= st_data_out;
          end else if (tmo_cnt == '0) begin
            state              <= RESP;
            rsp_valid[cur_idx] <= 1'b1;
            rsp_error          <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
